// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified single-port memory: IF fetch vs load/store.
// Grants one access per cycle and returns read data one cycle after the grant.
// Ports:
//   clk, rst (sync, active-low)
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata
//   d_req/d_we/d_be/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata -> memory, mem_rdata <- memory
// Optional macro MEM_ARB_PERF_EN adds perf_if_stall / perf_d_stall counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_d_stall
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  logic [CNT_W-1:0]  r_starve;
  logic [1:0]        r_owner;
  logic [DATA_W-1:0] r_if_hold;
  logic [DATA_W-1:0] r_d_hold;

  logic w_if_win;
  logic w_if_gnt;
  logic w_d_gnt;
  logic w_if_rvalid;
  logic w_d_rvalid;

  // IF wins when alone, or when it has been denied STARVE_MAX times in a row.
  assign w_if_win = if_req && (!d_req || (r_starve == STARVE_TOP));

  // Grants are masked during reset so no access (and no write) escapes.
  assign w_if_gnt = rst && w_if_win;
  assign w_d_gnt  = rst && d_req && !w_if_win;

  assign if_gnt = w_if_gnt;
  assign d_gnt  = w_d_gnt;

  assign mem_en    = w_if_gnt || w_d_gnt;
  assign mem_we    = w_d_gnt && d_we;
  assign mem_be    = w_d_gnt ? d_be : {BE_W{1'b1}};
  assign mem_addr  = w_d_gnt ? d_addr : if_addr;
  assign mem_wdata = d_wdata;

  // A pending return is dropped the moment reset is asserted.
  assign w_if_rvalid = rst && (r_owner == OWN_IF);
  assign w_d_rvalid  = rst && (r_owner == OWN_D);

  assign if_rvalid = w_if_rvalid;
  assign d_rvalid  = w_d_rvalid;

  // Memory data arrives in the rvalid cycle; the hold regs keep it afterwards.
  always_comb begin
    if_rdata = '0;
    d_rdata  = '0;
    if (rst) begin
      if_rdata = w_if_rvalid ? mem_rdata : r_if_hold;
      d_rdata  = w_d_rvalid  ? mem_rdata : r_d_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (!if_req || w_if_gnt) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_TOP) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= OWN_NONE;
    end else begin
      unique case (1'b1)
        w_if_gnt:           r_owner <= OWN_IF;
        (w_d_gnt && !d_we): r_owner <= OWN_D;
        default:            r_owner <= OWN_NONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_if_hold <= '0;
      r_d_hold  <= '0;
    end else begin
      if (w_if_rvalid) r_if_hold <= mem_rdata;
      if (w_d_rvalid)  r_d_hold  <= mem_rdata;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_if;
  logic [31:0] r_perf_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_if <= '0;
      r_perf_d  <= '0;
    end else begin
      if (if_req && !w_if_gnt) r_perf_if <= r_perf_if + 32'd1;
      if (d_req && !w_d_gnt)   r_perf_d  <= r_perf_d + 32'd1;
    end
  end

  assign perf_if_stall = r_perf_if;
  assign perf_d_stall  = r_perf_d;
`endif

endmodule
